// File: rtl/bin2bcd_byte_pkg.sv
// bin2bcd_byte_pkg
//   Shared constants for the byte-to-packed-BCD converter.
//   - FSM state encoding (IDLE / SHIFT / DONE)
//   - number of double-dabble shift cycles for an 8-bit input
//   - helper that picks the displayed byte for a finished conversion
package bin2bcd_byte_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int unsigned SHIFT_CYCLES = 8;
  localparam logic [2:0]  LAST_BIT     = 3'(SHIFT_CYCLES - 1);

  localparam logic [7:0]  CLAMP_BYTE   = 8'h99;

  // Final display byte: clamp to 99 when the hundreds digit is non-zero and
  // saturation is selected, otherwise drop the hundreds digit (value mod 100).
  function automatic logic [7:0] pick_display(input logic [1:0] hundreds,
                                              input logic [7:0] tens_ones,
                                              input logic       saturate);
    if (saturate && (hundreds != 2'd0)) begin
      return CLAMP_BYTE;
    end
    return tens_ones;
  endfunction

endpackage

// File: rtl/bin2bcd_byte_bcd_adj3.sv
// bcd_adj3
//   Double-dabble nibble correction: adds 3 when the nibble is 5 or more so
//   that the following left shift carries correctly into the next decade.
//   Ports:
//     din  - 4-bit BCD digit before the shift
//     dout - corrected digit
module bcd_adj3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin2bcd_byte.sv
// bin2bcd_byte
//   Iterative double-dabble converter from an unsigned byte to two packed BCD
//   digits for a seven-segment byte display. One conversion takes 10 cycles
//   (accept, 8 shifts, done).
//   Parameter:
//     SATURATE  - 1: values above 99 display as 99; 0: display value mod 100
//   Ports:
//     clk       - system clock, rising edge
//     reset     - asynchronous reset, active low
//     in_data   - binary value to convert, sampled on the accept edge
//     in_valid  - in_data is offered this cycle
//     in_ready  - block is idle and will accept in_valid
//     out_byte  - packed BCD {tens, ones}, held until the next completion
//     out_valid - one-cycle pulse after out_byte updates
//     overflow  - last converted value exceeded 99, held with out_byte
module bin2bcd_byte
  import bin2bcd_byte_pkg::*;
#(
  parameter bit SATURATE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_byte,
  output logic       out_valid,
  output logic       overflow
);

  logic [1:0] state_reg;
  logic [2:0] cnt_reg;
  logic [7:0] sr_reg;
  // scratch_reg = {hundreds[1:0], tens[3:0], ones[3:0]}
  logic [9:0] scratch_reg;
  logic [7:0] out_byte_reg;
  logic       out_valid_reg;
  logic       overflow_reg;

  logic [7:0] low_adj;
  logic [9:0] scratch_next;
  logic [7:0] sr_next;

  // Tens and ones get a corrector; hundreds only ever holds 0..2.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_adj
      bcd_adj3 u_adj (
        .din  (scratch_reg[gi*4 +: 4]),
        .dout (low_adj[gi*4 +: 4])
      );
    end
  endgenerate

  // Shift {scratch, sr} left by one after correction. Hundreds bit 9 is
  // never set before the final shift, so it is dropped here.
  always_comb begin
    scratch_next = {scratch_reg[8], low_adj, sr_reg[7]};
    sr_next      = {sr_reg[6:0], 1'b0};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 3'd0;
      sr_reg        <= 8'h00;
      scratch_reg   <= 10'd0;
      out_byte_reg  <= 8'h00;
      out_valid_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            sr_reg      <= in_data;
            scratch_reg <= 10'd0;
            cnt_reg     <= 3'd0;
            state_reg   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          scratch_reg <= scratch_next;
          sr_reg      <= sr_next;
          cnt_reg     <= cnt_reg + 3'd1;
          if (cnt_reg == LAST_BIT) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          overflow_reg  <= (scratch_reg[9:8] != 2'd0);
          out_byte_reg  <= pick_display(scratch_reg[9:8], scratch_reg[7:0], SATURATE);
          out_valid_reg <= 1'b1;
          state_reg     <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_byte  = out_byte_reg;
  assign out_valid = out_valid_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_bin2bcd_byte.sv
// tb_bin2bcd_byte
//   Directed bench for bin2bcd_byte. Two instances (SATURATE=1 and 0) share
//   the same stimulus so both overflow policies are checked on every vector.
module tb_bin2bcd_byte;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;

  logic       rdy_s, rdy_m;
  logic [7:0] byte_s, byte_m;
  logic       vld_s, vld_m;
  logic       ovf_s, ovf_m;

  int checks;
  int failures;

  bin2bcd_byte #(.SATURATE(1'b1)) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (rdy_s),
    .out_byte  (byte_s),
    .out_valid (vld_s),
    .overflow  (ovf_s)
  );

  bin2bcd_byte #(.SATURATE(1'b0)) dut_mod (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (rdy_m),
    .out_byte  (byte_m),
    .out_valid (vld_m),
    .overflow  (ovf_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits via division, independent of double-dabble.
  function automatic logic [7:0] ref_byte(input int v, input bit sat);
    int r;
    if (sat && v > 99) return 8'h99;
    r = v % 100;
    return 8'((r / 10) * 16 + (r % 10));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion with latency, pulse-width and hold checks.
  task automatic convert(input logic [7:0] v,
                         input logic [7:0] es, input logic eso,
                         input logic [7:0] em, input logic emo);
    int n;
    bit seen;
    n = 0;
    while (!rdy_s && n < 20) begin
      tick();
      n++;
    end
    check("ready_before", rdy_s, 1);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    check("accepted", rdy_s, 0);
    in_valid = 1'b0;
    in_data  = ~v;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      tick();
      n++;
      if (vld_s) seen = 1'b1;
    end
    check("latency", n, 9);
    check("sat_byte", byte_s, es);
    check("sat_ovf", ovf_s, eso);
    check("mod_byte", byte_m, em);
    check("mod_ovf", ovf_m, emo);
    check("mod_valid", vld_m, 1);
    check("ready_at_pulse", rdy_s, 1);
    tick();
    check("pulse_width", vld_s, 0);
    check("hold_byte", byte_s, es);
    $display("TXN in=%0d sat=%02h/%0d mod=%02h/%0d latency=%0d",
             v, byte_s, ovf_s, byte_m, ovf_m, n);
  endtask

  initial begin
    int pulses;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state
    tick();
    tick();
    check("rst_ready", rdy_s, 1);
    check("rst_byte", byte_s, 8'h00);
    check("rst_ovf", ovf_s, 0);
    check("rst_valid", vld_s, 0);
    reset = 1'b1;
    tick();

    // Directed vectors
    convert(8'd42,  8'h42, 1'b0, 8'h42, 1'b0);
    convert(8'd0,   8'h00, 1'b0, 8'h00, 1'b0);
    convert(8'd99,  8'h99, 1'b0, 8'h99, 1'b0);
    convert(8'd100, 8'h99, 1'b1, 8'h00, 1'b1);
    convert(8'd255, 8'h99, 1'b1, 8'h55, 1'b1);

    // Back-to-back with in_valid held: accepts at k=0,10,20
    in_valid = 1'b1;
    in_data  = 8'd7;
    tick();
    in_data = 8'd63;
    pulses  = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 9)  check("b2b_ready9", rdy_s, 1);
      if (k == 10) begin
        check("b2b_accept10", rdy_s, 0);
        in_data = 8'd200;
      end
      if (k == 20) begin
        check("b2b_accept20", rdy_s, 0);
        in_valid = 1'b0;
      end
      if (vld_s) begin
        pulses++;
        $display("TXN b2b k=%0d sat=%02h/%0d mod=%02h/%0d", k, byte_s, ovf_s, byte_m, ovf_m);
        if (pulses == 1) begin
          check("b2b_t1", k, 9);
          check("b2b_v1", byte_s, 8'h07);
        end else if (pulses == 2) begin
          check("b2b_t2", k, 19);
          check("b2b_v2", byte_s, 8'h63);
          check("b2b_o2", ovf_s, 0);
        end else if (pulses == 3) begin
          check("b2b_t3", k, 29);
          check("b2b_v3", byte_s, 8'h99);
          check("b2b_o3", ovf_s, 1);
          check("b2b_m3", byte_m, 8'h00);
        end
      end
    end
    check("b2b_pulses", pulses, 3);

    // Busy: a second request during the conversion is dropped
    in_valid = 1'b1;
    in_data  = 8'd5;
    tick();
    in_valid = 1'b0;
    pulses   = 0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 3) begin
        in_valid = 1'b1;
        in_data  = 8'd11;
      end
      tick();
      if (k == 3) in_valid = 1'b0;
      if (vld_s) begin
        pulses++;
        check("busy_t", k, 9);
        check("busy_v", byte_s, 8'h05);
      end
    end
    check("busy_pulses", pulses, 1);
    check("busy_hold", byte_s, 8'h05);
    $display("TXN busy in=5 ignored=11 out=%02h pulses=%0d", byte_s, pulses);

    // Reset aborts a conversion of 77
    in_valid = 1'b1;
    in_data  = 8'd77;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("abort_byte", byte_s, 8'h00);
    check("abort_ready", rdy_s, 1);
    check("abort_valid", vld_s, 0);
    tick();
    tick();
    reset  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (vld_s || vld_m) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    $display("TXN reset-abort in=77 out=%02h pulses=%0d", byte_s, pulses);

    // First offer after reset is accepted
    convert(8'd42, 8'h42, 1'b0, 8'h42, 1'b0);

    // Exhaustive sweep against the division-based reference
    for (int v = 0; v < 256; v++) begin
      convert(8'(v), ref_byte(v, 1'b1), (v > 99), ref_byte(v, 1'b0), (v > 99));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin2bcd_byte.md
BIN2BCD_BYTE -- requirements
Module: bin2bcd_byte

Interface
REQ-001 The block SHALL have one parameter: SATURATE, default 1, selects the overflow policy for inputs above 99 (1 = clamp display to 99, 0 = show the value modulo 100).
REQ-002 Port clk SHALL be an input, 1 bit wide: the single system clock; all state changes on the rising edge.
REQ-003 Port reset SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-004 Port in_data SHALL be an input, 8 bits wide: unsigned binary value to convert.
REQ-005 Port in_valid SHALL be an input, 1 bit wide: in_data is offered this cycle.
REQ-006 Port in_ready SHALL be an output, 1 bit wide: the block can accept a value this cycle.
REQ-007 Port out_byte SHALL be an output, 8 bits wide: packed BCD, tens in [7:4] and ones in [3:0], held steady between updates, feeding a two-digit seven-segment byte display.
REQ-008 Port out_valid SHALL be an output, 1 bit wide: one-cycle pulse in the cycle after out_byte updates.
REQ-009 Port overflow SHALL be an output, 1 bit wide: the last converted value exceeded 99; held with out_byte.

Function
REQ-010 The block SHALL be a three-state FSM with states IDLE, SHIFT and DONE, implementing iterative double-dabble conversion.
REQ-011 in_ready SHALL be 1 exactly when the state is IDLE, derived combinationally from the state.
REQ-012 An accept SHALL be a rising edge with in_valid=1 and in_ready=1; on it the block captures in_data into an 8-bit shift register, clears a 10-bit BCD scratch (hundreds[1:0], tens[3:0], ones[3:0]), clears a 3-bit bit counter and enters SHIFT.
REQ-013 Each SHIFT cycle SHALL first add 3 to every scratch nibble that is >=5, then shift {scratch, shift register} left by one, taking the MSB of the shift register into the ones LSB.
REQ-014 SHIFT SHALL last exactly 8 cycles (counter 0..7); on counter=7 the next state is DONE.
REQ-015 On the DONE edge, the block SHALL set overflow to (hundreds != 0).
REQ-016 On the DONE edge, the block SHALL load out_byte with {tens, ones} when hundreds=0.
REQ-017 On the DONE edge with hundreds != 0, the block SHALL load out_byte with 8'h99 if SATURATE=1, else with {tens, ones}.
REQ-018 On the DONE edge, the block SHALL set out_valid=1 and return to IDLE.
REQ-019 out_valid SHALL be cleared on every edge other than DONE, so it is high for exactly one cycle.
REQ-020 Latency SHALL be fixed: with the accept on edge E0, out_byte, overflow and out_valid change on edge E9, and in_ready is high again in the same cycle that out_valid is high.
REQ-021 Maximum throughput SHALL be one conversion per 10 cycles; with in_valid held high, a new accept occurs on edge E10.
REQ-022 in_valid while not in IDLE SHALL be ignored, with no queueing and no effect on the conversion in flight.
REQ-023 in_data SHALL be sampled only on the accept edge; later changes to in_data SHALL NOT affect the result.
REQ-024 out_byte and overflow SHALL hold their last values indefinitely while no conversion completes.

Reset
REQ-025 While reset=0, the state SHALL be IDLE, the bit counter, scratch and shift register 0, out_byte 8'h00, overflow 0 and out_valid 0; in_ready therefore reads 1.
REQ-026 Reset asserted mid-conversion SHALL abort the conversion, and no out_valid pulse SHALL follow.
REQ-027 After reset deassertion, the first rising edge with in_valid=1 SHALL be an accept.

Structure
REQ-028 The state encoding (IDLE, SHIFT, DONE) and the cycle count constant 8 SHALL live in the shared project package.
REQ-029 The nibble correction SHALL be one combinational sub-module, bcd_adj3 (4-bit in, 4-bit out, adds 3 when the input is >=5), instantiated for the tens and ones nibbles; the 2-bit hundreds field never reaches 5 and needs no adjuster.

Verification
REQ-030 Convert: in_data=42 accepted -> 9 cycles later out_valid pulse, out_byte=8'h42, overflow=0.
REQ-031 Boundaries: 0 -> 8'h00/0; 99 -> 8'h99/0; 100 with SATURATE=1 -> 8'h99/1; 255 with SATURATE=0 -> 8'h55/1.
REQ-032 Back-to-back: in_valid held high with values 7, 63, 200 -> accepts on E0, E10, E20; outputs 8'h07, 8'h63, then 8'h99 with overflow=1 (SATURATE=1).
REQ-033 Busy: in_valid pulsed with 11 at E3 of a conversion of 5 -> ignored; only 8'h05 is produced, and out_byte stays 8'h05 afterwards.
REQ-034 Reset: reset=0 at E4 of a conversion of 77 -> no out_valid pulse, out_byte=8'h00, in_ready=1 immediately.
REQ-035 Exhaustive: all inputs 0..255 for both SATURATE values checked against a reference model of (v % 100) or clamp, with the overflow flag.
